// File: rtl/mor1kx_traceport_emitter.sv
// Traceport producer: buffers retire events, pairs loads with their late writeback and
// emits them in program order. Optional build macro: MOR1KX_TRACEPORT_SKIP_NOP_EN.
`timescale 1ns/1ps
module mor1kx_traceport_emitter #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH_LOG2      = 2,
  parameter int unsigned WB_TIMEOUT           = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            retire_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] retire_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] retire_insn_i,
  input  logic                            retire_late_wb_i,
  input  logic                            retire_wben_i,
  input  logic [4:0]                      retire_wbreg_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] retire_wbdata_i,
  input  logic                            late_wb_valid_i,
  input  logic [4:0]                      late_wb_reg_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] late_wb_data_i,
  output logic                            traceport_exec_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] traceport_exec_pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] traceport_exec_insn_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] traceport_exec_wbdata_o,
  output logic [4:0]                      traceport_exec_wbreg_o,
  output logic                            traceport_exec_wben_o,
  output logic                            stall_o,
  output logic                            overflow_o,
  output logic                            timeout_o
);

  localparam int unsigned W      = OPTION_OPERAND_WIDTH;
  localparam int unsigned Aw     = FIFO_DEPTH_LOG2;
  localparam int unsigned Depth  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned TimerW = $clog2(WB_TIMEOUT + 1);

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] insn;
    logic         late;
    logic         wben;
    logic [4:0]   wbreg;
    logic [W-1:0] wbdata;
  } entry_t;

  typedef enum logic [0:0] {StEmit, StWaitWb} state_e;

  entry_t            fifo_q [Depth];
  logic [Aw-1:0]     wr_ptr_q, rd_ptr_q;
  logic [Aw:0]       count_q;
  logic              overflow_q;
  logic              hold_valid_q;
  logic [4:0]        hold_reg_q;
  logic [W-1:0]      hold_data_q;
  state_e            state_q;
  logic [TimerW-1:0] timer_q;

  logic              exec_valid_q, exec_wben_q, timeout_q;
  logic [W-1:0]      exec_pc_q, exec_insn_q, exec_wbdata_q;
  logic [4:0]        exec_wbreg_q;

  entry_t       head;
  logic         head_present, timer_done, skip, push_req, push_ok;
  logic         pop, consume, consume_live, wait_enter, to_evt;
  logic         wb_en;
  logic [4:0]   wb_reg;
  logic [W-1:0] wb_data;

  assign head         = fifo_q[rd_ptr_q];
  assign head_present = (count_q != '0);
  assign timer_done   = (timer_q == TimerW'(WB_TIMEOUT - 1));

`ifdef MOR1KX_TRACEPORT_SKIP_NOP_EN
  // Only the plain l.nop 0 is dropped; l.nop K carries simulation report/exit codes.
  assign skip = (retire_insn_i == W'(32'h1500_0000));
`else
  assign skip = 1'b0;
`endif

  assign push_req = retire_valid_i && !skip;
  assign push_ok  = push_req && ((count_q != (Aw+1)'(Depth)) || pop);

  // Pop decision and writeback source selection for the head entry.
  always_comb begin
    pop          = 1'b0;
    consume      = 1'b0;
    consume_live = 1'b0;
    wait_enter   = 1'b0;
    to_evt       = 1'b0;
    wb_en        = 1'b0;
    wb_reg       = '0;
    wb_data      = '0;
    unique case (state_q)
      StEmit: begin
        if (head_present) begin
          if (!head.late) begin
            pop     = 1'b1;
            wb_en   = head.wben;
            wb_reg  = head.wbreg;
            wb_data = head.wbdata;
          end else if (hold_valid_q) begin
            pop     = 1'b1;
            consume = 1'b1;
            wb_en   = 1'b1;
            wb_reg  = hold_reg_q;
            wb_data = hold_data_q;
          end else if (late_wb_valid_i) begin
            pop          = 1'b1;
            consume      = 1'b1;
            consume_live = 1'b1;
            wb_en        = 1'b1;
            wb_reg       = late_wb_reg_i;
            wb_data      = late_wb_data_i;
          end else begin
            wait_enter = 1'b1;
          end
        end
      end
      StWaitWb: begin
        if (late_wb_valid_i) begin
          pop          = 1'b1;
          consume      = 1'b1;
          consume_live = 1'b1;
          wb_en        = 1'b1;
          wb_reg       = late_wb_reg_i;
          wb_data      = late_wb_data_i;
        end else if (timer_done) begin
          pop    = 1'b1;
          to_evt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= '{pc: retire_pc_i, insn: retire_insn_i, late: retire_late_wb_i,
                            wben: retire_wben_i, wbreg: retire_wbreg_i,
                            wbdata: retire_wbdata_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_reg_q   <= '0;
      hold_data_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + Aw'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + (Aw+1)'(1);
        2'b01:   count_q <= count_q - (Aw+1)'(1);
        default: ;
      endcase
      if (push_req && !push_ok) overflow_q <= 1'b1;
      if (consume)              hold_valid_q <= late_wb_valid_i && !consume_live;
      else if (late_wb_valid_i) hold_valid_q <= 1'b1;
      if (late_wb_valid_i && !consume_live) begin
        hold_reg_q  <= late_wb_reg_i;
        hold_data_q <= late_wb_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StEmit;
      timer_q       <= '0;
      exec_valid_q  <= 1'b0;
      exec_pc_q     <= '0;
      exec_insn_q   <= '0;
      exec_wbdata_q <= '0;
      exec_wbreg_q  <= '0;
      exec_wben_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      exec_valid_q <= pop;
      timeout_q    <= to_evt;
      if (pop) begin
        exec_pc_q     <= head.pc;
        exec_insn_q   <= head.insn;
        exec_wben_q   <= wb_en;
        exec_wbreg_q  <= wb_reg;
        exec_wbdata_q <= wb_data;
      end
      unique case (state_q)
        StEmit: begin
          if (wait_enter) begin
            state_q <= StWaitWb;
            timer_q <= '0;
          end
        end
        StWaitWb: begin
          if (pop) state_q <= StEmit;
          else     timer_q <= timer_q + TimerW'(1);
        end
        default: state_q <= StEmit;
      endcase
    end
  end

  assign traceport_exec_valid_o  = exec_valid_q;
  assign traceport_exec_pc_o     = exec_pc_q;
  assign traceport_exec_insn_o   = exec_insn_q;
  assign traceport_exec_wbdata_o = exec_wbdata_q;
  assign traceport_exec_wbreg_o  = exec_wbreg_q;
  assign traceport_exec_wben_o   = exec_wben_q;
  assign stall_o                 = (count_q >= (Aw+1)'(Depth - 1));
  assign overflow_o              = overflow_q;
  assign timeout_o               = timeout_q;

endmodule

// File: tb/tb_mor1kx_traceport_emitter.sv
// Bench for mor1kx_traceport_emitter: directed timing scenarios plus a randomized
// program-order scoreboard run.
`timescale 1ns/1ps
module tb_mor1kx_traceport_emitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire_valid_i, retire_late_wb_i, retire_wben_i;
  logic [31:0] retire_pc_i, retire_insn_i, retire_wbdata_i;
  logic [4:0]  retire_wbreg_i;
  logic        late_wb_valid_i;
  logic [4:0]  late_wb_reg_i;
  logic [31:0] late_wb_data_i;
  logic        traceport_exec_valid_o, traceport_exec_wben_o;
  logic [31:0] traceport_exec_pc_o, traceport_exec_insn_o, traceport_exec_wbdata_o;
  logic [4:0]  traceport_exec_wbreg_o;
  logic        stall_o, overflow_o, timeout_o;

  always #5 clk = ~clk;

  mor1kx_traceport_emitter dut (
    .clk                     (clk),
    .rst                     (rst),
    .retire_valid_i          (retire_valid_i),
    .retire_pc_i             (retire_pc_i),
    .retire_insn_i           (retire_insn_i),
    .retire_late_wb_i        (retire_late_wb_i),
    .retire_wben_i           (retire_wben_i),
    .retire_wbreg_i          (retire_wbreg_i),
    .retire_wbdata_i         (retire_wbdata_i),
    .late_wb_valid_i         (late_wb_valid_i),
    .late_wb_reg_i           (late_wb_reg_i),
    .late_wb_data_i          (late_wb_data_i),
    .traceport_exec_valid_o  (traceport_exec_valid_o),
    .traceport_exec_pc_o     (traceport_exec_pc_o),
    .traceport_exec_insn_o   (traceport_exec_insn_o),
    .traceport_exec_wbdata_o (traceport_exec_wbdata_o),
    .traceport_exec_wbreg_o  (traceport_exec_wbreg_o),
    .traceport_exec_wben_o   (traceport_exec_wben_o),
    .stall_o                 (stall_o),
    .overflow_o              (overflow_o),
    .timeout_o               (timeout_o)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        wben;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
  } em_t;

  em_t         log_q[$];
  em_t         exp_q[$];
  int unsigned to_q[$];
  int unsigned cyc = 0;
  int unsigned c;
  int          errors = 0;
  int          checks = 0;
  logic        load_busy;
  logic [31:0] busy_pc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and log whatever the traceport shows after the edge.
  task automatic tick();
    em_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (traceport_exec_valid_o) begin
      e.cyc = cyc; e.pc = traceport_exec_pc_o; e.insn = traceport_exec_insn_o;
      e.wben = traceport_exec_wben_o; e.wbreg = traceport_exec_wbreg_o;
      e.wbdata = traceport_exec_wbdata_o;
      log_q.push_back(e);
      if (load_busy && traceport_exec_pc_o == busy_pc) load_busy = 1'b0;
    end
    if (timeout_o) to_q.push_back(cyc);
  endtask

  task automatic idle();
    retire_valid_i  = 1'b0;
    late_wb_valid_i = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic late,
                        input logic wben, input logic [4:0] rg, input logic [31:0] data);
    retire_valid_i = 1'b1; retire_pc_i = pc; retire_insn_i = insn;
    retire_late_wb_i = late; retire_wben_i = wben; retire_wbreg_i = rg;
    retire_wbdata_i = data;
  endtask

  task automatic late_wb(input logic [4:0] rg, input logic [31:0] data);
    late_wb_valid_i = 1'b1; late_wb_reg_i = rg; late_wb_data_i = data;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    log_q.delete();
    to_q.delete();
    load_busy = 1'b0;
  endtask

  function automatic logic [127:0] wbf(input em_t e);
    return {e.wben, e.wbreg, e.wbdata};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, insn, data;
    logic [4:0]  rg;
    logic        wben;
    int          wb_cnt;
    int          d;
    logic [4:0]  pend_reg;
    logic [31:0] pend_data;

    rst = 1'b1; idle();
    retire_pc_i = '0; retire_insn_i = '0; retire_late_wb_i = 1'b0; retire_wben_i = 1'b0;
    retire_wbreg_i = '0; retire_wbdata_i = '0; late_wb_reg_i = '0; late_wb_data_i = '0;
    load_busy = 1'b0; busy_pc = '0;

    // Reset state
    do_reset();
    chk("rst_valid", traceport_exec_valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_fields", {traceport_exec_pc_o, traceport_exec_insn_o, traceport_exec_wben_o,
                       traceport_exec_wbreg_o, traceport_exec_wbdata_o}, 0);

    // Three back-to-back retires: emitted at t+2..t+4
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      retire(32'h100 + 32'(4 * i), 32'hE063_1800, 1'b0, 1'b1, 5'd3, 32'hA5);
      tick();
    end
    idle();
    repeat (4) tick();
    chk("b2b_count", 128'(log_q.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (log_q.size() > i) begin
        chk("b2b_pc", log_q[i].pc, 32'h100 + 32'(4 * i));
        chk("b2b_cycle", 128'(log_q[i].cyc), 128'(c + 2 + i));
        chk("b2b_wb", wbf(log_q[i]), {1'b1, 5'd3, 32'hA5});
      end
    end
    chk("hold_pc", traceport_exec_pc_o, 32'h108);
    chk("hold_valid_low", traceport_exec_valid_o, 0);

    // Load with writeback three cycles later, followed by an add
    do_reset();
    c = cyc;
    retire(32'h200, 32'h84A3_0000, 1'b1, 1'b0, 5'd0, 32'h0); tick();
    retire(32'h204, 32'hE0E3_1800, 1'b0, 1'b1, 5'd7, 32'h11); tick();
    idle(); tick();
    late_wb(5'd5, 32'hDEADBEEF); tick();
    idle();
    repeat (4) tick();
    chk("load_count", 128'(log_q.size()), 2);
    if (log_q.size() > 1) begin
      chk("load_pc", log_q[0].pc, 32'h200);
      chk("load_wb", wbf(log_q[0]), {1'b1, 5'd5, 32'hDEADBEEF});
      chk("load_cycle", 128'(log_q[0].cyc), 128'(c + 4));
      chk("add_pc", log_q[1].pc, 32'h204);
      chk("add_wb", wbf(log_q[1]), {1'b1, 5'd7, 32'h11});
      chk("add_cycle", 128'(log_q[1].cyc), 128'(c + 5));
    end

    // Late writeback never arrives: timeout 16 cycles after entering the wait
    do_reset();
    c = cyc;
    retire(32'h300, 32'h84A3_0000, 1'b1, 1'b0, 5'd0, 32'h0); tick();
    idle();
    repeat (24) tick();
    chk("to_count", 128'(log_q.size()), 1);
    chk("to_pulses", 128'(to_q.size()), 1);
    if (log_q.size() > 0) begin
      chk("to_pc", log_q[0].pc, 32'h300);
      chk("to_wb", wbf(log_q[0]), 0);
      chk("to_cycle", 128'(log_q[0].cyc), 128'(c + 18));
    end
    if (to_q.size() > 0) chk("to_pulse_cycle", 128'(to_q[0]), 128'(c + 18));

    // Six retires behind a waiting load: stall at 3, drops set sticky overflow
    do_reset();
    retire(32'h400, 32'h84A3_0000, 1'b1, 1'b0, 5'd0, 32'h0); tick();
    retire(32'h404, 32'hE000_0000, 1'b0, 1'b1, 5'd1, 32'h1); tick();
    chk("ovf_stall_at2", stall_o, 0);
    retire(32'h408, 32'hE000_0000, 1'b0, 1'b1, 5'd1, 32'h2); tick();
    chk("ovf_stall_at3", stall_o, 1);
    retire(32'h40C, 32'hE000_0000, 1'b0, 1'b1, 5'd1, 32'h3); tick();
    chk("ovf_full_no_ovf", overflow_o, 0);
    retire(32'h410, 32'hE000_0000, 1'b0, 1'b1, 5'd1, 32'h4); tick();
    chk("ovf_set", overflow_o, 1);
    retire(32'h414, 32'hE000_0000, 1'b0, 1'b1, 5'd1, 32'h5); tick();
    idle();
    repeat (3) tick();
    chk("ovf_sticky", overflow_o, 1);
    late_wb(5'd6, 32'h66); tick();
    idle();
    repeat (8) tick();
    chk("ovf_drain_count", 128'(log_q.size()), 4);
    if (log_q.size() > 3) chk("ovf_last_pc", log_q[3].pc, 32'h40C);
    chk("ovf_sticky_after_drain", overflow_o, 1);
    chk("ovf_stall_after_drain", stall_o, 0);

    // Push into a full FIFO accepted when the waiting load pops that cycle
    do_reset();
    retire(32'h500, 32'h84A3_0000, 1'b1, 1'b0, 5'd0, 32'h0); tick();
    for (int i = 1; i < 4; i++) begin
      retire(32'h500 + 32'(4 * i), 32'hE000_0000, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
    end
    chk("pp_stall_full", stall_o, 1);
    retire(32'h510, 32'hE000_0000, 1'b0, 1'b1, 5'd2, 32'h22);
    late_wb(5'd9, 32'h99);
    tick();
    idle();
    chk("pp_no_ovf", overflow_o, 0);
    repeat (8) tick();
    chk("pp_count", 128'(log_q.size()), 5);
    if (log_q.size() > 4) begin
      chk("pp_load_wb", wbf(log_q[0]), {1'b1, 5'd9, 32'h99});
      chk("pp_last_pc", log_q[4].pc, 32'h510);
    end
    chk("pp_no_ovf_end", overflow_o, 0);

    // Retire and late writeback in the same cycle on an empty FIFO
    do_reset();
    c = cyc;
    retire(32'h600, 32'h84A3_0000, 1'b1, 1'b0, 5'd0, 32'h0);
    late_wb(5'd10, 32'hCAFEF00D);
    tick();
    idle();
    repeat (4) tick();
    chk("same_count", 128'(log_q.size()), 1);
    if (log_q.size() > 0) begin
      chk("same_cycle", 128'(log_q[0].cyc), 128'(c + 2));
      chk("same_wb", wbf(log_q[0]), {1'b1, 5'd10, 32'hCAFEF00D});
    end

    // l.nop 0 versus l.nop 1
    do_reset();
    retire(32'h700, 32'h1500_0000, 1'b0, 1'b0, 5'd0, 32'h0); tick();
    retire(32'h704, 32'h1500_0001, 1'b0, 1'b0, 5'd0, 32'h0); tick();
    idle();
    repeat (4) tick();
`ifdef MOR1KX_TRACEPORT_SKIP_NOP_EN
    chk("nop_count", 128'(log_q.size()), 1);
`else
    chk("nop_count", 128'(log_q.size()), 2);
    if (log_q.size() > 0) chk("nop_first", log_q[0].insn, 32'h1500_0000);
`endif
    if (log_q.size() > 0) chk("nop_last", log_q[log_q.size()-1].insn, 32'h1500_0001);

    // Randomized traffic honouring stall_o; model keeps expected program order
    do_reset();
    exp_q.delete();
    pc = 32'h1000;
    wb_cnt = -1;
    pend_reg = '0;
    pend_data = '0;
    for (int k = 0; k < 400; k++) begin
      idle();
      if (wb_cnt == 0) begin
        late_wb(pend_reg, pend_data);
        wb_cnt = -1;
      end else if (wb_cnt > 0) begin
        wb_cnt--;
      end
      if (k < 380 && !stall_o && $urandom_range(99) < 65) begin
        em_t e;
        rg = 5'($urandom_range(31));
        data = $urandom;
        if (!load_busy && wb_cnt < 0 && !late_wb_valid_i && $urandom_range(3) == 0) begin
          retire(pc, 32'h8400_0000 | 32'($urandom_range(16'hFFFF)), 1'b1, 1'b0, 5'd0, 32'h0);
          d = $urandom_range(5);
          pend_reg = rg;
          pend_data = data;
          if (d == 0) late_wb(rg, data);
          else wb_cnt = d;
          load_busy = 1'b1;
          busy_pc = pc;
          e.pc = pc; e.insn = retire_insn_i; e.wben = 1'b1; e.wbreg = rg; e.wbdata = data;
          exp_q.push_back(e);
        end else begin
          insn = ($urandom_range(9) == 0) ? 32'h1500_0000 : $urandom;
          wben = 1'($urandom_range(1));
          retire(pc, insn, 1'b0, wben, rg, data);
          e.pc = pc; e.insn = insn; e.wben = wben; e.wbreg = rg; e.wbdata = data;
`ifdef MOR1KX_TRACEPORT_SKIP_NOP_EN
          if (insn != 32'h1500_0000) exp_q.push_back(e);
`else
          exp_q.push_back(e);
`endif
        end
        pc = pc + 32'd4;
      end
      tick();
    end
    idle();
    for (int w = 0; w < 100 && log_q.size() < exp_q.size(); w++) tick();
    chk("rnd_count", 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk("rnd_event", {log_q[i].pc, log_q[i].insn, wbf(log_q[i])},
          {exp_q[i].pc, exp_q[i].insn, wbf(exp_q[i])});
    end
    chk("rnd_no_timeout", 128'(to_q.size()), 0);
    chk("rnd_no_overflow", overflow_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mor1kx_traceport_emitter.md
Name: mor1kx_traceport_emitter

Overview:
Producer side of the mor1kx execution traceport, consumed by the per-core traceport monitor in simulation benches. Accepts one retire event per cycle from the ctrl stage. Pairs load-type instructions with their late register-file writeback and buffers events in a small FIFO. Drives the traceport_exec_* bundle in strict program order, at most one instruction per cycle, for every core instance in single- and multi-core systems.

Parameters:
OPTION_OPERAND_WIDTH, 32, width of pc, insn and wbdata fields
FIFO_DEPTH_LOG2, 2, log2 of event FIFO depth (default 4 entries)
WB_TIMEOUT, 16, cycles to wait for a late writeback before emitting without it

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
retire_valid_i  in  1  instruction retired this cycle
retire_pc_i  in  32  retired pc
retire_insn_i  in  32  retired instruction word
retire_late_wb_i  in  1  writeback arrives later via late_wb_* (loads)
retire_wben_i  in  1  immediate writeback enable (ignored when late)
retire_wbreg_i  in  5  immediate writeback register
retire_wbdata_i  in  32  immediate writeback data
late_wb_valid_i  in  1  late writeback strobe
late_wb_reg_i  in  5  late writeback register
late_wb_data_i  in  32  late writeback data
traceport_exec_valid_o  out  1  one-cycle strobe per emitted instruction
traceport_exec_pc_o  out  32  emitted pc
traceport_exec_insn_o  out  32  emitted insn
traceport_exec_wbdata_o  out  32  emitted writeback data
traceport_exec_wbreg_o  out  5  emitted writeback register
traceport_exec_wben_o  out  1  emitted writeback enable
stall_o  out  1  backpressure to pipeline
overflow_o  out  1  sticky: event dropped
timeout_o  out  1  one-cycle pulse: late writeback timed out

Behaviour:
- Reset: all outputs 0; FIFO empty; holding register invalid; state EMIT; timeout counter 0. Reset mid-wait discards all pending events.
- Push: retire_valid_i high writes {pc, insn, late, wben, wbreg, wbdata} at FIFO tail. A push into a full FIFO is dropped and sets overflow_o until reset.
- stall_o = registered count >= DEPTH-1.
- Holding register: every late_wb_valid_i captures {reg, data} and sets hold_valid. Only one late instruction is outstanding; a late writeback never precedes its retire. Same-cycle retire and late writeback is legal.
- FSM EMIT: head present and head.late=0 -> pop; outputs register head fields with valid=1.
- EMIT, head.late=1, hold_valid=1 (including one captured in the same cycle) -> pop; emit wben=1, wbreg/wbdata from holding register; clear hold_valid.
- EMIT, head.late=1, hold_valid=0 -> WAIT_WB, counter cleared.
- WAIT_WB: late_wb_valid_i -> emit the head with that data this edge (bypass), return to EMIT.
- WAIT_WB: counter reaching WB_TIMEOUT-1 -> emit the head with wben=0, wbreg=0, wbdata=0; pulse timeout_o; return to EMIT.
- traceport_exec_valid_o is high exactly one cycle per pop. Other outputs hold their last values when valid=0.
- Latency: retire in cycle t with FIFO empty -> valid in cycle t+2. Sustained throughput 1/cycle.
- Push and pop in the same cycle leave count unchanged. A push is accepted while full if a pop occurs in that cycle.
- Pointers wrap modulo DEPTH. Count is FIFO_DEPTH_LOG2+1 bits.

Optional Feature:
MOR1KX_TRACEPORT_SKIP_NOP_EN:
- Defined: retire events with insn == 0x15000000 (l.nop 0) are not pushed. l.nop with nonzero K, used for report/exit, is still emitted.
- Undefined: every retire event is pushed.

Test Plan:
- Three back-to-back retires (pc 0x100, 0x104, 0x108, wben=1, reg 3, data 0xA5) -> valid high cycles t+2..t+4 in order, fields unchanged.
- Load at pc 0x200 (late=1), late wb reg 5, data 0xDEADBEEF 3 cycles later; then add at 0x204 -> 0x200 emitted with wben=1, reg 5, 0xDEADBEEF, then 0x204, order kept.
- Late instruction with no writeback, WB_TIMEOUT=16 -> emitted with wben=0 exactly 16 cycles after entering WAIT_WB; timeout_o pulses once.
- Six retires with no drain possible (head late, waiting) -> stall_o at count 3; 5th accepted only if pop coincides, else overflow_o=1 and stays 1.
- Retire plus late wb in the same cycle, FIFO empty -> single emit at t+2 with late data.
- With the macro defined: retire insns 0x15000000 and 0x15000001 -> only 0x15000001 emitted. Without the macro: both emitted.
